// File: rtl/scoreboard_pkg.sv
// Shared scoreboard definitions: opcode encodings, responder FSM states and
// functional-unit index constants.
package scoreboard_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OPC_W-1:0] OP_AND  = 4'd2;
    localparam logic [OPC_W-1:0] OP_OR   = 4'd3;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'd5;
    localparam logic [OPC_W-1:0] OP_SLL  = 4'd6;
    localparam logic [OPC_W-1:0] OP_SRL  = 4'd7;
    localparam logic [OPC_W-1:0] OP_PASS = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_OPS = 2'd1,
        ST_EXEC     = 2'd2,
        ST_WAIT_WB  = 2'd3
    } fu_state_e;

    localparam logic [7:0] FU_INT  = 8'd0;
    localparam logic [7:0] FU_FADD = 8'd1;
    localparam logic [7:0] FU_FMUL = 8'd2;
    localparam logic [7:0] FU_FDIV = 8'd3;

endpackage

// File: rtl/fu_alu.sv
// Combinational ALU behind the scoreboard responder; all results wrap modulo
// 2^DATA_W, and an unknown opcode yields zero with err set.
module fu_alu
    import scoreboard_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              err
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        y   = '0;
        err = 1'b0;
        case (op)
            OP_W'(OP_ADD):  y = a + b;
            OP_W'(OP_SUB):  y = a - b;
            OP_W'(OP_AND):  y = a & b;
            OP_W'(OP_OR):   y = a | b;
            OP_W'(OP_XOR):  y = a ^ b;
            OP_W'(OP_MUL):  y = a * b;
            OP_W'(OP_SLL):  y = a << shamt;
            OP_W'(OP_SRL):  y = a >> shamt;
            OP_W'(OP_PASS): y = a;
            default:        err = 1'b1;
        endcase
    end

endmodule

// File: rtl/fu_scoreboard_responder.sv
// Functional-unit responder to the scoreboard: accept one issue, capture
// operands on read grant, run for LATENCY cycles, hold the result until write grant.
module fu_scoreboard_responder
    import scoreboard_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int OP_W    = 4,
    parameter int LATENCY = 4,
    parameter int FU_ID   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [REG_AW-1:0] issue_fi,
    input  logic [REG_AW-1:0] issue_fj,
    input  logic [REG_AW-1:0] issue_fk,
    output logic              busy,
    output logic [REG_AW-1:0] rd_fj,
    output logic [REG_AW-1:0] rd_fk,
    input  logic              rd_grant,
    input  logic [DATA_W-1:0] opj_data,
    input  logic [DATA_W-1:0] opk_data,
    output logic              wr_req,
    output logic [REG_AW-1:0] wr_dest,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_grant,
    output logic              op_err,
    output logic [7:0]        fu_id
);

    localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

    fu_state_e         state_q,   state_d;
    logic [7:0]        cnt_q,     cnt_d;
    logic              busy_q,    busy_d;
    logic              wr_req_q,  wr_req_d;
    logic              op_err_q,  op_err_d;
    logic [REG_AW-1:0] fi_q,      fi_d;
    logic [REG_AW-1:0] fj_q,      fj_d;
    logic [REG_AW-1:0] fk_q,      fk_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [OP_W-1:0]   op_q,      op_d;
    logic [DATA_W-1:0] opj_q,     opj_d;
    logic [DATA_W-1:0] opk_q,     opk_d;

    logic [DATA_W-1:0] alu_y;
    logic              alu_err;

    fu_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .op  (op_q),
        .a   (opj_q),
        .b   (opk_q),
        .y   (alu_y),
        .err (alu_err)
    );

    assign issue_ready = ~busy_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        wr_req_d  = wr_req_q;
        op_err_d  = op_err_q;
        fi_d      = fi_q;
        fj_d      = fj_q;
        fk_d      = fk_q;
        wr_data_d = wr_data_q;
        op_d      = op_q;
        opj_d     = opj_q;
        opk_d     = opk_q;

        case (state_q)
            ST_IDLE: begin
                if (issue_valid && issue_ready) begin
                    state_d = ST_WAIT_OPS;
                    busy_d  = 1'b1;
                    op_d    = issue_op;
                    fi_d    = issue_fi;
                    fj_d    = issue_fj;
                    fk_d    = issue_fk;
                end
            end
            ST_WAIT_OPS: begin
                if (rd_grant) begin
                    state_d = ST_EXEC;
                    opj_d   = opj_data;
                    opk_d   = opk_data;
                    cnt_d   = '0;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d   = ST_WAIT_WB;
                    wr_req_d  = 1'b1;
                    wr_data_d = alu_y;
                    op_err_d  = alu_err;
                end
            end
            ST_WAIT_WB: begin
                // Result fields stay frozen here; only the grant moves us on.
                if (wr_grant) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    wr_req_d = 1'b0;
                    op_err_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            wr_req_q  <= 1'b0;
            op_err_q  <= 1'b0;
            fi_q      <= '0;
            fj_q      <= '0;
            fk_q      <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            wr_req_q  <= wr_req_d;
            op_err_q  <= op_err_d;
            fi_q      <= fi_d;
            fj_q      <= fj_d;
            fk_q      <= fk_d;
            wr_data_q <= wr_data_d;
        end
    end

    // NOTE: opcode and operand latches are left unreset; they are always
    // rewritten before the ALU result is captured, so reset adds nothing.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        opj_q <= opj_d;
        opk_q <= opk_d;
    end

    assign busy    = busy_q;
    assign rd_fj   = fj_q;
    assign rd_fk   = fk_q;
    assign wr_req  = wr_req_q;
    assign wr_dest = fi_q;
    assign wr_data = wr_data_q;
    assign op_err  = op_err_q;
    assign fu_id   = 8'(FU_ID);

endmodule
